// File: rtl/byte_link_pkg.sv
// Shared types and helpers for both ends of the two-wire byte link.
package byte_link_pkg;

  typedef logic [7:0] t_byte;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } t_tx_state;

  localparam int C_DATA_BITS = 8;

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic parity_even(input t_byte data);
    return ^data;
  endfunction

endpackage

// File: rtl/byte_link_fifo.sv
// Small synchronous first-word-fall-through FIFO with occupancy count.
module byte_link_fifo #(
  parameter int P_DEPTH = 4,
  parameter int P_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [P_WIDTH-1:0]         wdata,
  output logic [P_WIDTH-1:0]         rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(P_DEPTH):0]   level
);

  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0]   C_FULL    = P_DEPTH[AW:0];
  localparam logic [AW:0]   C_LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] C_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == C_FULL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only safe when the same edge frees a slot.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + C_PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + C_PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + C_LVL_ONE;
        2'b01:   level <= level - C_LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/byte_link_tx.sv
// Transmit end of the two-wire byte link: buffers bytes and sends LSB-first
// frames on ser_out, starting a new frame only while the far end is not holding.
//
// state  | meaning
// IDLE   | line high; start a frame when a byte is queued and hold is low
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (only when P_PARITY=1)
// STOP   | stop bit (high); frame counted on its last cycle
module byte_link_tx
  import byte_link_pkg::*;
#(
  parameter int P_DIV    = 4,
  parameter int P_PARITY = 0,
  parameter int P_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  t_byte                    in_data,
  output logic                     ser_out,
  input  logic                     ser_hold,
  output logic                     busy,
  output logic [$clog2(P_DEPTH):0] level,
  output logic [15:0]              frame_cnt
);

  localparam logic [7:0] C_BAUD_LOAD = 8'(P_DIV - 1);
  localparam logic [2:0] C_LAST_BIT  = 3'(C_DATA_BITS - 1);

  t_tx_state state;
  logic [7:0] baud;
  logic [2:0] bit_cnt;
  t_byte      shift;
  logic       parity_bit;
  logic       hold_meta;
  logic       hold_s;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  t_byte      rdata;

  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) & ~empty & ~hold_s;
  assign busy     = (state != IDLE) | (level != '0);

  byte_link_fifo #(
    .P_DEPTH (P_DEPTH),
    .P_WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_meta <= 1'b0;
      hold_s    <= 1'b0;
    end else begin
      hold_meta <= ser_hold;
      hold_s    <= hold_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      ser_out    <= 1'b1;
      frame_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ser_out <= 1'b1;
          if (pop) begin
            shift      <= rdata;
            parity_bit <= parity_even(rdata);
            bit_cnt    <= '0;
            baud       <= C_BAUD_LOAD;
            ser_out    <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          if (baud == '0) begin
            baud    <= C_BAUD_LOAD;
            ser_out <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end else begin
            baud <= baud - 8'd1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud <= C_BAUD_LOAD;
            if (bit_cnt == C_LAST_BIT) begin
              if (P_PARITY != 0) begin
                ser_out <= parity_bit;
                state   <= PARITY;
              end else begin
                ser_out <= 1'b1;
                state   <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              ser_out <= shift[0];
              shift   <= shift >> 1;
            end
          end else begin
            baud <= baud - 8'd1;
          end
        end
        PARITY: begin
          if (baud == '0) begin
            baud    <= C_BAUD_LOAD;
            ser_out <= 1'b1;
            state   <= STOP;
          end else begin
            baud <= baud - 8'd1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            ser_out   <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end else begin
            baud <= baud - 8'd1;
          end
        end
        default: begin
          ser_out <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/byte_link_tx.md
Name: byte_link_tx

Overview:
Transmit end of the two-wire byte link. The receiving end samples serial data on its `one` input and drives back-pressure on its `two` output; this block is the transmitter on the opposite side.
- Accepts bytes on a valid/ready stream and buffers them in a small FIFO.
- Serialises each byte as an LSB-first frame on ser_out, at P_DIV clocks per bit.
- Honours the far-end hold line, but only at frame boundaries.

Parameters:
- P_DIV, 4, clock cycles per serial bit; legal range 2..255.
- P_PARITY, 0, 0 = no parity bit, 1 = even parity bit after the data bits.
- P_DEPTH, 4, FIFO depth in bytes; power of two, 2..16.

Ports:
- Interface decision: one clock, clk. Reset is rst: asynchronous, active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  upstream byte valid.
- in_ready  out  1  FIFO can accept a byte.
- in_data  in  8  byte to send (t_byte).
- ser_out  out  1  serial line; idle-high.
- ser_hold  in  1  far-end hold; asynchronous to clk.
- busy  out  1  frame in progress or FIFO non-empty.
- level  out  $clog2(P_DEPTH)+1  FIFO occupancy.
- frame_cnt  out  16  frames completed; wraps.

Behaviour:
- Reset values (rst high, applied asynchronously): ser_out=1, in_ready=1, busy=0, level=0, frame_cnt=0, state=IDLE, FIFO empty, hold synchroniser=0.
- Input handshake: a byte transfers on a clk edge where in_valid and in_ready are both 1.
  - in_ready = (level != P_DEPTH).
  - A push and a pop in the same cycle leave level unchanged. This is legal when full, but in_ready is still 0 when full (no combinational path from the pop).
  - in_data is ignored when in_valid=0.
- Hold: ser_hold passes through a 2-flop synchroniser; hold_s is its output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: ser_out=1. If FIFO non-empty and hold_s=0: pop into shift register and go to START. The bit counter loads 0 and the baud counter loads P_DIV-1.
  - START: ser_out=0 for P_DIV cycles, then DATA.
  - DATA: ser_out=shift[0] for P_DIV cycles per bit, shift right, 8 bits. Then PARITY if P_PARITY=1, else STOP.
  - PARITY: ser_out = XOR of the 8 data bits (even parity), for P_DIV cycles.
  - STOP: ser_out=1 for P_DIV cycles. On the last stop cycle, frame_cnt increments (16-bit wrap, 0xFFFF->0x0000).
  - After STOP, the next state is always IDLE. There are no back-to-back frames without passing through IDLE, so there is a minimum 1-cycle idle gap.
- Frame timing:
  - Byte accepted at edge E into an empty FIFO with the FSM idle and hold_s=0: ser_out falls at edge E+1 (pop in IDLE during the cycle after E; registered output).
  - Frame length is (10+P_PARITY)*P_DIV cycles.
- Hold semantics: sampled only in IDLE. A hold asserted mid-frame never truncates or stretches the current frame; it blocks the next start.
- ser_out is driven from a flop; there is no combinational path from any input.
- busy = (state != IDLE) || (level != 0).
- Reset mid-frame: ser_out returns to 1 immediately. FIFO contents are discarded and no partial frame resumes.

Decomposition:
- Package byte_link_pkg:
  - typedef t_byte (logic [7:0]);
  - typedef enum t_tx_state {IDLE, START, DATA, PARITY, STOP};
  - localparam C_DATA_BITS = 8;
  - function parity_even(t_byte).
- The receiving end imports the same package.
- One sub-module: byte_link_fifo. Parameters P_DEPTH and P_WIDTH=8. Ports: clk, rst, push, pop, wdata, rdata, full, empty, level. Synchronous FIFO with first-word fall-through and async reset.

Test Plan:
- Single byte 0xA5, P_DIV=4, P_PARITY=0 -> ser_out low 4 cycles starting 1 edge after acceptance, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; frame_cnt=1.
- 0x07 with P_PARITY=1 -> parity bit=1; frame is 44 cycles at P_DIV=4; 0x03 gives parity bit 0.
- Burst of 6 bytes 0x00..0x05, in_valid held, P_DEPTH=4 -> in_ready drops once level=4; all 6 frames appear in order; frame_cnt=6; busy falls after the final STOP.
- ser_hold pulsed high mid-frame of 0x3C with 0x3D queued -> 0x3C completes intact; 0x3D starts only ≥3 cycles after hold releases; ser_out stays high while hold_s=1.
- rst asserted during DATA bit 3 of 0xFF with 2 bytes queued -> ser_out=1 and level=0 in the same cycle as rst; no frame after release until a new push.
- Preload frame_cnt to 0xFFFF (by sending 65535 frames, or via a force) and send one byte -> frame_cnt=0x0000.
